// File: rtl/score_keeper.sv
// Two-player BCD score keeper: debounced buttons, win detection,
// and outputs that change only on a vertical-sync frame strobe.
module score_keeper #(
   parameter int DEB_CYCLES = 250000,
   parameter int WIN_SCORE  = 21
) (
   input  logic       clk_sk,
   input  logic       rst_sk,
   input  logic       btn_a_sk,
   input  logic       btn_b_sk,
   input  logic       btn_clr_sk,
   input  logic       v_sk,
   output logic [7:0] score_a_sk,
   output logic [7:0] score_b_sk,
   output logic [1:0] winner_sk
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);
   localparam logic [7:0] WIN_BCD =
      8'(((WIN_SCORE / 10) * 16) + (WIN_SCORE % 10));

   typedef enum logic [1:0] {
      PLAY  = 2'b00,
      WIN_A = 2'b01,
      WIN_B = 2'b10
   } state_t;

   logic [2:0]    sync1;
   logic [2:0]    sync2;
   logic [2:0]    stable;
   logic [CW-1:0] cnt [3];
   logic [2:0]    rise;

   state_t     state;
   state_t     state_n;
   logic [7:0] sc_a;
   logic [7:0] sc_b;
   logic [7:0] sc_a_n;
   logic [7:0] sc_b_n;
   logic [7:0] inc_a;
   logic [7:0] inc_b;

   logic v_q;
   logic strobe;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'h99)
         r = v;
      else if (v[3:0] == 4'd9)
         r = {v[7:4] + 4'd1, 4'd0};
      else
         r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   // bit 0 = A, bit 1 = B, bit 2 = clear
   always_ff @(posedge clk_sk or negedge rst_sk) begin
      if (!rst_sk) begin
         sync1  <= '0;
         sync2  <= '0;
         stable <= '0;
         for (int i = 0; i < 3; i++)
            cnt[i] <= '0;
      end else begin
         sync1 <= {btn_clr_sk, btn_b_sk, btn_a_sk};
         sync2 <= sync1;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CMAX) begin
               cnt[i]    <= '0;
               stable[i] <= ~stable[i];
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   // press pulse coincides with the 0->1 toggle of the stable level
   always_comb begin
      rise = '0;
      for (int i = 0; i < 3; i++)
         rise[i] = sync2[i] & ~stable[i] & (cnt[i] == CMAX);
   end

   always_ff @(posedge clk_sk or negedge rst_sk) begin
      if (!rst_sk) begin
         state <= PLAY;
         sc_a  <= '0;
         sc_b  <= '0;
      end else begin
         state <= state_n;
         sc_a  <= sc_a_n;
         sc_b  <= sc_b_n;
      end
   end

   always_comb begin
      state_n = state;
      sc_a_n  = sc_a;
      sc_b_n  = sc_b;
      inc_a   = bcd_inc(sc_a);
      inc_b   = bcd_inc(sc_b);
      if (rise[2]) begin
         state_n = PLAY;
         sc_a_n  = '0;
         sc_b_n  = '0;
      end else if (state == PLAY) begin
         if (rise[0]) begin
            sc_a_n = inc_a;
            if (inc_a == WIN_BCD)
               state_n = WIN_A;
         end else if (rise[1]) begin
            sc_b_n = inc_b;
            if (inc_b == WIN_BCD)
               state_n = WIN_B;
         end
      end
   end

   assign strobe = v_q & ~v_sk;

   always_ff @(posedge clk_sk or negedge rst_sk) begin
      if (!rst_sk) begin
         v_q        <= 1'b1;
         score_a_sk <= '0;
         score_b_sk <= '0;
         winner_sk  <= '0;
      end else begin
         v_q <= v_sk;
         if (strobe) begin
            score_a_sk <= sc_a;
            score_b_sk <= sc_b;
            winner_sk  <= state;
         end
      end
   end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper, DEB_CYCLES=4 with WIN_SCORE=3
// on the main instance and WIN_SCORE=99 on a second one.
module tb_score_keeper;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_a = 1'b0;
   logic       btn_b = 1'b0;
   logic       btn_c = 1'b0;
   logic       btn_a2 = 1'b0;
   logic       v = 1'b1;
   logic [7:0] sa, sb, sa2, sb2;
   logic [1:0] win, win2;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   score_keeper #(.DEB_CYCLES(4), .WIN_SCORE(3)) dut (
      .clk_sk(clk), .rst_sk(rst),
      .btn_a_sk(btn_a), .btn_b_sk(btn_b), .btn_clr_sk(btn_c),
      .v_sk(v),
      .score_a_sk(sa), .score_b_sk(sb), .winner_sk(win)
   );

   score_keeper #(.DEB_CYCLES(4), .WIN_SCORE(99)) dut99 (
      .clk_sk(clk), .rst_sk(rst),
      .btn_a_sk(btn_a2), .btn_b_sk(btn_b), .btn_clr_sk(btn_c),
      .v_sk(v),
      .score_a_sk(sa2), .score_b_sk(sb2), .winner_sk(win2)
   );

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit a, input bit b,
                        input bit c, input bit a2);
      @(negedge clk);
      btn_a = a; btn_b = b; btn_c = c; btn_a2 = a2;
      wait_n(10);
      btn_a = 0; btn_b = 0; btn_c = 0; btn_a2 = 0;
      wait_n(10);
   endtask

   task automatic frame();
      @(negedge clk);
      v = 1'b0;
      @(negedge clk);
      v = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      n_vec++;
      if (sa !== 8'h00 || sb !== 8'h00 || win !== 2'b00) begin
         n_err++;
         $display("FAIL reset_init: got %h/%h/%b want 00/00/00",
                  sa, sb, win);
      end
      press(1, 0, 0, 0);
      press(1, 0, 0, 0);
      press(0, 1, 0, 0);
      frame();
      n_vec++;
      if (sa !== 8'h02 || sb !== 8'h01) begin
         n_err++;
         $display("FAIL pre_reset: got %h/%h want 02/01", sa, sb);
      end
      @(negedge clk);
      #1 rst = 1'b0;
      btn_a = 1'b1;
      #1;
      n_vec++;
      if (sa !== 8'h00 || sb !== 8'h00 || win !== 2'b00) begin
         n_err++;
         $display("FAIL async_reset: got %h/%h/%b want 00/00/00",
                  sa, sb, win);
      end
      wait_n(3);
      rst = 1'b1;
      wait_n(15);
      btn_a = 1'b0;
      wait_n(10);
      frame();
      n_vec++;
      if (sa !== 8'h01 || sb !== 8'h00) begin
         n_err++;
         $display("FAIL held_thru_reset: got %h/%h want 01/00",
                  sa, sb);
      end
      press(0, 0, 1, 0);
   endtask

   task automatic test_bounce();
      frame();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         btn_a = (i % 2 == 0);
         @(negedge clk);
      end
      btn_a = 1'b1;
      wait_n(20);
      btn_a = 1'b0;
      wait_n(12);
      frame();
      n_vec++;
      if (sa !== 8'h01) begin
         n_err++;
         $display("FAIL bounce: got %h want 01", sa);
      end
      @(negedge clk);
      btn_a = 1'b1;
      wait_n(3);
      btn_a = 1'b0;
      wait_n(12);
      frame();
      n_vec++;
      if (sa !== 8'h01) begin
         n_err++;
         $display("FAIL glitch: got %h want 01", sa);
      end
      press(0, 0, 1, 0);
   endtask

   task automatic test_frame_sync();
      frame();
      press(1, 0, 0, 0);
      n_vec++;
      if (sa !== 8'h00) begin
         n_err++;
         $display("FAIL hold_v_high: got %h want 00", sa);
      end
      @(negedge clk);
      v = 1'b0;
      #1;
      n_vec++;
      if (sa !== 8'h00) begin
         n_err++;
         $display("FAIL before_strobe_edge: got %h want 00", sa);
      end
      @(negedge clk);
      n_vec++;
      if (sa !== 8'h01) begin
         n_err++;
         $display("FAIL after_strobe: got %h want 01", sa);
      end
      press(1, 0, 0, 0);
      n_vec++;
      if (sa !== 8'h01) begin
         n_err++;
         $display("FAIL hold_v_low: got %h want 01", sa);
      end
      @(negedge clk);
      v = 1'b1;
      wait_n(3);
      n_vec++;
      if (sa !== 8'h01) begin
         n_err++;
         $display("FAIL v_rise_no_strobe: got %h want 01", sa);
      end
      frame();
      n_vec++;
      if (sa !== 8'h02) begin
         n_err++;
         $display("FAIL next_strobe: got %h want 02", sa);
      end
      press(0, 0, 1, 0);
   endtask

   task automatic test_win();
      for (int i = 0; i < 3; i++)
         press(1, 0, 0, 0);
      frame();
      n_vec++;
      if (sa !== 8'h03 || sb !== 8'h00 || win !== 2'b01) begin
         n_err++;
         $display("FAIL win_a: got %h/%h/%b want 03/00/01",
                  sa, sb, win);
      end
      press(1, 0, 0, 0);
      press(1, 0, 0, 0);
      press(0, 1, 0, 0);
      frame();
      n_vec++;
      if (sa !== 8'h03 || sb !== 8'h00 || win !== 2'b01) begin
         n_err++;
         $display("FAIL win_hold: got %h/%h/%b want 03/00/01",
                  sa, sb, win);
      end
      press(0, 0, 1, 0);
      for (int i = 0; i < 3; i++)
         press(0, 1, 0, 0);
      frame();
      n_vec++;
      if (sa !== 8'h00 || sb !== 8'h03 || win !== 2'b10) begin
         n_err++;
         $display("FAIL win_b: got %h/%h/%b want 00/03/10",
                  sa, sb, win);
      end
      press(0, 0, 1, 0);
      frame();
      n_vec++;
      if (sa !== 8'h00 || sb !== 8'h00 || win !== 2'b00) begin
         n_err++;
         $display("FAIL clear_from_win: got %h/%h/%b want 00/00/00",
                  sa, sb, win);
      end
   endtask

   task automatic test_simultaneous();
      press(1, 0, 0, 0);
      press(1, 1, 0, 0);
      frame();
      n_vec++;
      if (sa !== 8'h02 || sb !== 8'h00 || win !== 2'b00) begin
         n_err++;
         $display("FAIL a_b_same: got %h/%h/%b want 02/00/00",
                  sa, sb, win);
      end
      press(1, 0, 1, 0);
      frame();
      n_vec++;
      if (sa !== 8'h00 || sb !== 8'h00 || win !== 2'b00) begin
         n_err++;
         $display("FAIL a_clr_same: got %h/%h/%b want 00/00/00",
                  sa, sb, win);
      end
   endtask

   task automatic test_bcd_carry();
      press(0, 0, 1, 0);
      for (int i = 0; i < 10; i++)
         press(0, 0, 0, 1);
      frame();
      n_vec++;
      if (sa2 !== 8'h10 || win2 !== 2'b00) begin
         n_err++;
         $display("FAIL bcd_10: got %h/%b want 10/00", sa2, win2);
      end
      for (int i = 0; i < 9; i++)
         press(0, 0, 0, 1);
      frame();
      n_vec++;
      if (sa2 !== 8'h19 || sb2 !== 8'h00) begin
         n_err++;
         $display("FAIL bcd_19: got %h/%h want 19/00", sa2, sb2);
      end
   endtask

   initial begin
      wait_n(3);
      rst = 1'b1;
      wait_n(2);
      test_reset();
      test_bounce();
      test_frame_sync();
      test_win();
      test_simultaneous();
      test_bcd_carry();
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter DEB_CYCLES, default 250000, meaning: stable cycles required before a button level is accepted (10 ms at 25 MHz).
REQ-002 Parameter WIN_SCORE, default 21, meaning: decimal score ending a game, legal range 1..99.
REQ-003 clk_sk  input  1  pixel clock from the clock divider (25 MHz), sole clock; all logic on rising edge.
REQ-004 rst_sk  input  1  asynchronous, active-low reset.
REQ-005 btn_a_sk  input  1  raw player-A button, asynchronous, active-high.
REQ-006 btn_b_sk  input  1  raw player-B button, asynchronous, active-high.
REQ-007 btn_clr_sk  input  1  raw clear button, asynchronous, active-high.
REQ-008 v_sk  input  1  vertical sync from the VGA timing block, active-low.
REQ-009 score_a_sk  output  8  player-A score, BCD, [7:4] tens, [3:0] units, frame-stable.
REQ-010 score_b_sk  output  8  player-B score, BCD, same format, frame-stable.
REQ-011 winner_sk  output  2  00 game running, 01 A won, 10 B won, 11 never driven; frame-stable.

Function
REQ-012 Each button SHALL pass a 2-flop synchronizer, then a debouncer: per-button counter of ceil(log2(DEB_CYCLES)) bits, cleared whenever synced level equals stable level, stable level toggles when counter reaches DEB_CYCLES-1.
REQ-013 A press SHALL be a one-cycle pulse on a 0->1 transition of the stable level; release generates nothing; held button generates exactly one pulse.
REQ-014 Button-to-pulse latency SHALL be 2 sync cycles + DEB_CYCLES cycles of stable input.
REQ-015 Internal scores sc_a, sc_b SHALL be 8-bit BCD; increment adds 1 to units, units 9 -> 0 with tens +1; no non-BCD digit ever stored.
REQ-016 FSM states PLAY, WIN_A, WIN_B; reset state PLAY.
REQ-017 PLAY, A pulse: sc_a increments next cycle; if the incremented value equals WIN_SCORE, state -> WIN_A same edge.
REQ-018 PLAY, B pulse: sc_b increments; if equal to WIN_SCORE, state -> WIN_B same edge.
REQ-019 A and B pulses in the same cycle: A is processed, B pulse is dropped.
REQ-020 WIN_A / WIN_B: A and B pulses ignored; scores hold.
REQ-021 Clear pulse in any state: sc_a = sc_b = 00, state -> PLAY next edge; clear has priority over simultaneous A/B pulses.
REQ-022 Score saturates at 99 (reachable only by misconfiguration); 99 + 1 keeps 99.
REQ-023 v_sk SHALL be registered; a frame strobe is the single cycle where registered v_sk is 1 and current v_sk is 0.
REQ-024 On a frame strobe, score_a_sk, score_b_sk, winner_sk SHALL load sc_a, sc_b, encoded state; otherwise hold.
REQ-025 Display latency: internal change visible one cycle after the next frame strobe; change in the strobe cycle itself appears at the following strobe.
REQ-026 v_sk held low or high indefinitely: outputs hold; internal scoring continues.

Reset
REQ-027 rst_sk low SHALL immediately, without clock, force score_a_sk = 00, score_b_sk = 00, winner_sk = 00, sc_a = sc_b = 00, state PLAY, debounce counters 0, stable levels 0, synchronizers 0, registered v_sk 1.
REQ-028 Reset asserted mid-debounce or mid-game SHALL discard pending presses; a button still held at reset release produces one pulse after DEB_CYCLES.
REQ-029 Deassertion is synchronous to clk_sk by external reset synchronizer; block requires no extra cycles after release.

Verification (DEB_CYCLES = 4, WIN_SCORE = 3 unless stated)
REQ-030 Reset: rst_sk low mid-game with scores 02/01 -> all outputs 00 within same time step, no clock edge needed.
REQ-031 Bounce: btn_a_sk toggles every 2 cycles for 20 cycles then holds high -> exactly one A increment; 3-cycle glitch -> none.
REQ-032 BCD carry (WIN_SCORE = 99): 10 A presses, one frame strobe -> score_a_sk = 8'h10; 9 more -> 8'h19.
REQ-033 Win: 3 A presses -> winner_sk = 01 after next strobe; 2 further A, B presses -> scores stay 03/00.
REQ-034 Simultaneous: A and B pulses same cycle -> sc_a +1, sc_b unchanged; A and clear same cycle -> 00/00, PLAY.
REQ-035 Frame sync: score change with v_sk high -> outputs unchanged until v_sk falls, then updated exactly one cycle after the falling-edge cycle.
